// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST sequencer for a single-port RAM with a 1-cycle read.
// Owns the memory while running, records the first mismatch, then hands the memory back.
module mbist_march_ctrl #(
   parameter int addr = 3,
   parameter int data = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [data-1:0] mem_dout,
   output logic            test_mode,
   output logic            mbist_rd,
   output logic            mbist_wr,
   output logic [addr-1:0] mbist_addr,
   output logic [data-1:0] mbist_din,
   output logic            busy,
   output logic            done,
   output logic            fail,
   output logic [addr-1:0] fail_addr,
   output logic [2:0]      fail_element
);

   typedef enum logic [2:0] {
      IDLE, WR0, RD, WR, RDF, CMPF, DONE
   } state_t;

   localparam logic [addr-1:0] top_a = '1;

   state_t          state_q, state_d;
   logic [addr-1:0] a_q, a_d;
   logic [2:0]      el_q, el_d;
   logic            fail_q, fail_d;
   logic [addr-1:0] fa_q, fa_d;
   logic [2:0]      fe_q, fe_d;
   logic [data-1:0] din_q;
   logic [data-1:0] wdata;
   logic [data-1:0] rd_exp;
   logic [data-1:0] wr_bg;
   logic            mism;
   logic            last;
   logic            up;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         el_q    <= '0;
         fail_q  <= 1'b0;
         fa_q    <= '0;
         fe_q    <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         el_q    <= el_d;
         fail_q  <= fail_d;
         fa_q    <= fa_d;
         fe_q    <= fe_d;
         din_q   <= mbist_din;
      end
   end

   // E2/E4 read back ones; odd elements write ones.
   assign rd_exp = (el_q == 3'd2 || el_q == 3'd4) ? '1 : '0;
   assign wr_bg  = el_q[0] ? '1 : '0;
   assign up     = (el_q < 3'd3);
   assign last   = up ? (a_q == top_a) : (a_q == '0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      el_d      = el_q;
      fail_d    = fail_q;
      fa_d      = fa_q;
      fe_d      = fe_q;
      test_mode = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      mbist_rd  = 1'b0;
      mbist_wr  = 1'b0;
      wdata     = '0;
      mism      = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               state_d = WR0;
               a_d     = '0;
               el_d    = '0;
               fail_d  = 1'b0;
               fa_d    = '0;
               fe_d    = '0;
            end
         end
         WR0: begin
            test_mode = 1'b1;
            busy      = 1'b1;
            mbist_wr  = 1'b1;
            if (a_q == top_a) begin
               state_d = RD;
               el_d    = 3'd1;
               a_d     = '0;
            end else begin
               a_d = a_q + 1'b1;
            end
         end
         RD: begin
            test_mode = 1'b1;
            busy      = 1'b1;
            mbist_rd  = 1'b1;
            state_d   = WR;
         end
         WR: begin
            test_mode = 1'b1;
            busy      = 1'b1;
            mbist_wr  = 1'b1;
            wdata     = wr_bg;
            mism      = (mem_dout != rd_exp);
            state_d   = RD;
            if (last) begin
               unique case (el_q)
                  3'd1: begin
                     el_d = 3'd2;
                     a_d  = '0;
                  end
                  3'd2, 3'd3: begin
                     el_d = el_q + 3'd1;
                     a_d  = top_a;
                  end
                  default: begin
                     state_d = RDF;
                     el_d    = 3'd5;
                     a_d     = top_a;
                  end
               endcase
            end else if (up) begin
               a_d = a_q + 1'b1;
            end else begin
               a_d = a_q - 1'b1;
            end
         end
         RDF: begin
            test_mode = 1'b1;
            busy      = 1'b1;
            mbist_rd  = 1'b1;
            state_d   = CMPF;
         end
         CMPF: begin
            test_mode = 1'b1;
            busy      = 1'b1;
            mism      = (mem_dout != '0);
            if (a_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = RDF;
               a_d     = a_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (mism && !fail_q) begin
         fail_d = 1'b1;
         fa_d   = a_q;
         fe_d   = el_q;
      end
   end

   // Write data is only driven in write cycles; otherwise it holds.
   assign mbist_din    = mbist_wr ? wdata : din_q;
   assign mbist_addr   = a_q;
   assign fail         = fail_q;
   assign fail_addr    = fa_q;
   assign fail_element = fe_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural 8x8 RAM
// that can inject a stuck-at-1 bit or a blocked-write fault.
module tb_mbist_march_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] mem_dout;
   logic       test_mode;
   logic       mbist_rd;
   logic       mbist_wr;
   logic [2:0] mbist_addr;
   logic [7:0] mbist_din;
   logic       busy;
   logic       done;
   logic       fail;
   logic [2:0] fail_addr;
   logic [2:0] fail_element;

   int n_cmp = 0;
   int n_err = 0;

   logic       stuck5;
   logic       block2;
   logic [7:0] mem [8];
   int         wcnt;
   logic [2:0] tr_addr [128];
   logic       tr_wr [128];
   logic       tr_rd [128];
   int         bidx;

   mbist_march_ctrl #(.addr(3), .data(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mem_dout     (mem_dout),
      .test_mode    (test_mode),
      .mbist_rd     (mbist_rd),
      .mbist_wr     (mbist_wr),
      .mbist_addr   (mbist_addr),
      .mbist_din    (mbist_din),
      .busy         (busy),
      .done         (done),
      .fail         (fail),
      .fail_addr    (fail_addr),
      .fail_element (fail_element)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with optional faults; read data registered one cycle.
   always @(posedge clk) begin
      if (mbist_wr) begin
         if (!(block2 && mbist_addr == 3'd2 && wcnt >= 8))
            mem[mbist_addr] <= mbist_din;
         wcnt <= wcnt + 1;
      end else if (!busy) begin
         wcnt <= 0;
      end
      if (mbist_rd)
         mem_dout <= mem[mbist_addr] |
                     ((stuck5 && mbist_addr == 3'd5) ? 8'h01 : 8'h00);
   end

   always @(posedge clk) begin
      if (busy) begin
         if (bidx < 128) begin
            tr_addr[bidx] <= mbist_addr;
            tr_wr[bidx]   <= mbist_wr;
            tr_rd[bidx]   <= mbist_rd;
         end
         bidx <= bidx + 1;
      end else begin
         bidx <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_wait(output int cnt);
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         if (busy) cnt++;
         if (done) break;
         @(negedge clk);
      end
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask

   int cnt;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      stuck5 = 1'b0;
      block2 = 1'b0;
      wcnt   = 0;
      bidx   = 0;
      mem_dout = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_test_mode", {31'd0, test_mode}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_strobes", {30'd0, mbist_rd, mbist_wr}, 32'd0);
      chk("rst_addr_din", {21'd0, mbist_addr, mbist_din}, 32'd0);
      chk("rst_fail", {25'd0, fail, fail_addr, fail_element}, 32'd0);
      rst = 1'b0;

      // Clean run
      pulse_start();
      chk("run1_first_busy", {31'd0, busy}, 32'd1);
      chk("run1_test_mode", {31'd0, test_mode}, 32'd1);
      run_wait(cnt);
      chk("run1_cycles", cnt, 32'd88);
      chk("run1_fail", {31'd0, fail}, 32'd0);
      chk("run1_test_mode_off", {31'd0, test_mode}, 32'd0);
      chk("run1_busy_off", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("e0_addr", {29'd0, tr_addr[i]}, i);
         chk("e0_wr", {31'd0, tr_wr[i]}, 32'd1);
      end
      chk("e3_first_addr", {29'd0, tr_addr[40]}, 32'd7);
      chk("e3_first_rd", {31'd0, tr_rd[40]}, 32'd1);
      chk("e5_last_addr", {29'd0, tr_addr[86]}, 32'd0);

      // Stuck-at-1 on bit 0 of address 5
      stuck5 = 1'b1;
      pulse_start();
      chk("stuck_clears_done", {31'd0, done}, 32'd0);
      run_wait(cnt);
      stuck5 = 1'b0;
      chk("stuck_cycles", cnt, 32'd88);
      chk("stuck_fail", {31'd0, fail}, 32'd1);
      chk("stuck_fail_addr", {29'd0, fail_addr}, 32'd5);
      chk("stuck_fail_elem", {29'd0, fail_element}, 32'd1);

      // Writes to address 2 blocked after E0
      block2 = 1'b1;
      pulse_start();
      chk("blk_clears_fail", {31'd0, fail}, 32'd0);
      run_wait(cnt);
      block2 = 1'b0;
      chk("blk_cycles", cnt, 32'd88);
      chk("blk_fail", {31'd0, fail}, 32'd1);
      chk("blk_fail_addr", {29'd0, fail_addr}, 32'd2);
      chk("blk_fail_elem", {29'd0, fail_element}, 32'd2);

      // start held high across a failing run, then a clean restart
      stuck5 = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      run_wait(cnt);
      chk("held_cycles", cnt, 32'd88);
      chk("held_fail", {31'd0, fail}, 32'd1);
      stuck5 = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("restart_done_clr", {31'd0, done}, 32'd0);
      chk("restart_fail_clr", {31'd0, fail}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      run_wait(cnt);
      chk("rerun_cycles", cnt, 32'd88);
      chk("rerun_fail", {31'd0, fail}, 32'd0);

      // Reset in the middle of a run
      pulse_start();
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 40; i++) begin
         if (busy) cnt++;
         if (cnt < 40) @(negedge clk);
      end
      chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_test_mode", {31'd0, test_mode}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_strobes", {30'd0, mbist_rd, mbist_wr}, 32'd0);
      chk("mid_rst_addr_din", {21'd0, mbist_addr, mbist_din}, 32'd0);
      chk("mid_rst_status", {25'd0, done, fail, fail_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulse_start();
      run_wait(cnt);
      chk("post_rst_cycles", cnt, 32'd88);
      chk("post_rst_fail", {31'd0, fail}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- MBIST controller that sequences a March C- test over the single-port test memory through the mbist_* ports of the memory wrapper.
- Asserts test_mode so the wrapper routes MBIST signals to the memory, steps the march elements, and compares read data on mem_dout against the expected background.
- Reports done/fail with first-failure address and element, then releases the memory to the CPU by dropping test_mode.

Parameters:
- addr, 3, memory address width; depth = 2^addr.
- data, 8, memory word width; backgrounds are all-0s / all-1s of this width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  test request; sampled only in IDLE or DONE.
- mem_dout  in  data  memory read data; valid the cycle after mbist_rd (1-cycle registered read).
- test_mode  out  1  wrapper select: 1 = MBIST owns memory.
- mbist_rd  out  1  memory read strobe.
- mbist_wr  out  1  memory write strobe.
- mbist_addr  out  addr  memory address.
- mbist_din  out  data  memory write data.
- busy  out  1  test in progress.
- done  out  1  test complete; held until the next accepted start or rst.
- fail  out  1  at least one mismatch seen in the current run.
- fail_addr  out  addr  address of the first mismatch.
- fail_element  out  3  march element (0-5) of the first mismatch.

Behaviour:
- Reset (asynchronous): every output is 0; state goes to IDLE. Reset mid-test aborts immediately; test_mode = 0 returns the memory to the CPU, and no write completes after rst is asserted.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 down(r0)
  - "up" runs addresses 0 to 2^addr-1; "down" runs 2^addr-1 to 0.
- States: IDLE, WR0 (E0), RD, WR (E1-E4, element held in a register), RDF, CMPF (E5), DONE.
- Start: start=1 at a posedge in IDLE or DONE moves to WR0 with addr=0. That edge also clears done, fail, fail_addr and fail_element. start in any other state is ignored.
- Outputs in WR0/RD/WR/RDF/CMPF: test_mode = 1, busy = 1. Exactly one of mbist_rd or mbist_wr is high, except in CMPF where both are 0.
- WR0: 1 cycle per address, mbist_wr = 1, din = all-0. After the last address, go to RD with element 1, addr 0.
- RD: mbist_rd = 1 for 1 cycle. Next state is WR at the same address.
- WR:
  - mbist_wr = 1, din = the element's write background.
  - In the same cycle, mem_dout is compared with the expected read background: E1/E3 expect 0s, E2/E4 expect 1s.
  - On the last address of the element, advance to the next element at its start address. E3 and E4 start at 2^addr-1.
- RDF/CMPF (E5): RDF issues the read (mbist_rd = 1). CMPF compares mem_dout with 0s, then moves to the next lower address. After address 0, go to DONE.
- Mismatch:
  - Any bit differing in a compare cycle sets fail.
  - fail_addr and fail_element capture the first mismatch only; later mismatches never overwrite them.
  - The test always runs to completion (no stop-on-fail).
- DONE: busy = 0, done = 1, test_mode = 0, strobes 0; fail and its capture fields are held.
- Run length: exactly 11·2^addr busy cycles (88 for addr=3). done rises on the edge that ends the last CMPF.
- Address counter: addr bits with an explicit terminal compare; wrap-around is never used to detect element end.
- When mbist_rd and mbist_wr are both 0, mbist_din and mbist_addr hold their last values.

Test Plan:
- Fault-free memory, addr=3/data=8: pulse start for 1 cycle. Busy stays high 88 cycles, then done=1, fail=0, test_mode=0. Write order: E0 addresses 0..7; first E3 access at address 7.
- Bit 0 of address 5 forced stuck-at-1: fail=1, fail_addr=5, fail_element=1. Test still completes in 88 cycles.
- Writes to address 2 blocked after E0 (word stays 8'h00): first mismatch gives fail_addr=2, fail_element=2 (r1 read returns 8'h00).
- rst asserted at busy cycle 40: all outputs 0 immediately and test_mode=0. A following start runs a clean 88-cycle test.
- start held high throughout a run: no restart while busy. A new run begins on the edge after done rises, and that edge clears done and fail.
- After a failing run, start again with a fault-free memory: fail is cleared at start and stays 0; done rises after 88 cycles.
